// File: rtl/mecanismo_flipping_pipeline.sv
// ---------------------------------------------------------------------------
// mecanismo_flipping_pipeline
//
// Purpose:
//   Elastic two-stage flipping stage that sits between the activation
//   buffer and the PE-array input bus. Every cycle it can take one set of
//   M activations (N bits each). Each activation is either inverted or
//   passed through, which lowers toggling on the downstream bus. The flip
//   decision comes from one of two places:
//     - external mode (in_mode=0): the per-channel input_f_bits;
//     - auto mode (in_mode=1): bus-invert coding. A channel is inverted
//       when more than N/2 bits would otherwise toggle against the last
//       word sent on that channel.
//   A saturating counter accumulates how many channel flips have been
//   delivered to the consumer.
//
// Ports:
//   clk                  rising-edge clock
//   rst                  asynchronous, active-low reset
//   in_valid/in_ready    input handshake
//   in_mode              0 = external flip bits, 1 = automatic bus-invert
//   input_f_bits         per-channel flip request (external mode)
//   input_activaciones   M x N raw activations, channel ch at [ch]
//   out_valid/out_ready  output handshake
//   salida_activaciones  M x N processed activations
//   salida_f_bits        flip flag actually applied, per channel
//   flip_count           saturating count of delivered channel flips
//   clear_count          synchronous clear of flip_count (beats increment)
// ---------------------------------------------------------------------------
module mecanismo_flipping_pipeline #(
    parameter int N     = 16,
    parameter int M     = 16,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_mode,
    input  logic [M-1:0]          input_f_bits,
    input  logic [M-1:0][N-1:0]   input_activaciones,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [M-1:0][N-1:0]   salida_activaciones,
    output logic [M-1:0]          salida_f_bits,
    output logic [CNT_W-1:0]      flip_count,
    input  logic                  clear_count
);

    localparam int PC_N  = $clog2(N + 1);
    localparam int PC_M  = $clog2(M + 1);
    localparam int SUM_W = ((CNT_W > PC_M) ? CNT_W : PC_M) + 1;

    localparam logic [PC_N-1:0]  HALF    = PC_N'(N / 2);
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    // Number of ones in one activation word.
    function automatic logic [PC_N-1:0] popcount_word(input logic [N-1:0] v);
        logic [PC_N-1:0] acc;
        acc = '0;
        for (int i = 0; i < N; i++) begin
            acc = acc + PC_N'(v[i]);
        end
        return acc;
    endfunction

    // Number of channels flagged as flipped in one word-set.
    function automatic logic [PC_M-1:0] popcount_flags(input logic [M-1:0] v);
        logic [PC_M-1:0] acc;
        acc = '0;
        for (int i = 0; i < M; i++) begin
            acc = acc + PC_M'(v[i]);
        end
        return acc;
    endfunction

    // Stage 1 holds raw input; stage 2 is the output register.
    logic                s1_valid;
    logic                s1_mode;
    logic [M-1:0]        s1_f;
    logic [M-1:0][N-1:0] s1_data;
    logic                s2_valid;

    logic                s2_ready;
    logic                in_fire;
    logic                s1_to_s2;
    logic                out_fire;

    logic [M-1:0]        auto_f;
    logic [M-1:0]        f_next;
    logic [M-1:0][N-1:0] b_next;

    logic [SUM_W-1:0]    cnt_sum;
    logic [CNT_W-1:0]    cnt_next;

    // The ready chain depends only on the valid flags and out_ready, never
    // on data, so it cannot form a combinational path through the payload.
    assign s2_ready  = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_ready;
    assign in_fire   = in_valid && in_ready;
    assign s1_to_s2  = s1_valid && s2_ready;
    assign out_fire  = s2_valid && out_ready;
    assign out_valid = s2_valid;

    // Stage 1 captures the word-set on an input handshake. It may reload in
    // the same cycle that its old contents move into stage 2. It only goes
    // empty when it drains with nothing new arriving.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_mode  <= 1'b0;
            s1_f     <= '0;
            s1_data  <= '0;
        end else begin
            if (in_fire) begin
                s1_valid <= 1'b1;
                s1_mode  <= in_mode;
                s1_f     <= input_f_bits;
                s1_data  <= input_activaciones;
            end else if (s1_to_s2) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Bus-invert decision. The output register always holds the last value
    // driven on each channel, so it serves directly as last[ch]. It updates
    // only on an S1->S2 transfer and is cleared by reset, which is exactly
    // the required behaviour of last[]. A tie at N/2 does not flip.
    always_comb begin
        auto_f = '0;
        for (int ch = 0; ch < M; ch++) begin
            auto_f[ch] = popcount_word(s1_data[ch] ^ salida_activaciones[ch]) > HALF;
        end
    end

    assign f_next = s1_mode ? auto_f : s1_f;

    // Apply the chosen flip to each channel.
    always_comb begin
        b_next = '0;
        for (int ch = 0; ch < M; ch++) begin
            b_next[ch] = f_next[ch] ? ~s1_data[ch] : s1_data[ch];
        end
    end

    // Stage 2 loads on every S1->S2 transfer and holds stable while stalled.
    // A plain output handshake with no refill empties it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid            <= 1'b0;
            salida_activaciones <= '0;
            salida_f_bits       <= '0;
        end else begin
            if (s1_to_s2) begin
                s2_valid            <= 1'b1;
                salida_activaciones <= b_next;
                salida_f_bits       <= f_next;
            end else if (out_fire) begin
                s2_valid <= 1'b0;
            end
        end
    end

    // The sum is formed one bit wider than either operand, so an overflow
    // shows up as a value above the maximum and is clamped, never wrapped.
    assign cnt_sum  = SUM_W'(flip_count) + SUM_W'(popcount_flags(salida_f_bits));
    assign cnt_next = (cnt_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : cnt_sum[CNT_W-1:0];

    // Flip statistics. Only delivered words are counted. A clear takes
    // priority over an increment in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flip_count <= '0;
        end else begin
            if (clear_count) begin
                flip_count <= '0;
            end else if (out_fire) begin
                flip_count <= cnt_next;
            end
        end
    end

endmodule

// File: tb/tb_mecanismo_flipping_pipeline.sv
// ---------------------------------------------------------------------------
// tb_mecanismo_flipping_pipeline
//
// Scoreboard bench for the flipping pipeline (N=16, M=16, CNT_W=4).
// The stimulus pushes a hand-computed expected word-set for every input.
// A separate monitor pops that entry and compares it on every output
// handshake. The monitor also tracks the expected saturating flip count
// from the expected flags.
//
// Only channels 0 and 1 carry interesting data. All other channels are
// driven to 0, and their expected value is given as one "rest" value.
// ---------------------------------------------------------------------------
module tb_mecanismo_flipping_pipeline;

    localparam int N     = 16;
    localparam int M     = 16;
    localparam int CNT_W = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic                in_mode;
    logic [M-1:0]        input_f_bits;
    logic [M-1:0][N-1:0] input_activaciones;
    logic                out_valid;
    logic                out_ready;
    logic [M-1:0][N-1:0] salida_activaciones;
    logic [M-1:0]        salida_f_bits;
    logic [CNT_W-1:0]    flip_count;
    logic                clear_count;

    typedef struct {
        logic [M-1:0][N-1:0] data;
        logic [M-1:0]        f;
    } exp_t;

    exp_t             sb[$];
    exp_t             mon_e;
    int               checks = 0;
    int               errors = 0;
    logic [CNT_W-1:0] cnt_model;
    int               mon_sum;
    int               w;

    mecanismo_flipping_pipeline #(.N(N), .M(M), .CNT_W(CNT_W)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in_mode             (in_mode),
        .input_f_bits        (input_f_bits),
        .input_activaciones  (input_activaciones),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .salida_activaciones (salida_activaciones),
        .salida_f_bits       (salida_f_bits),
        .flip_count          (flip_count),
        .clear_count         (clear_count)
    );

    // 10-unit clock period.
    always #5 clk = ~clk;

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string name, input logic [255:0] actual,
                               input logic [255:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    // Queues the expected result, then presents one word-set until it is
    // accepted. The task is entered and left just after a rising edge, and
    // the handshake is sampled at the falling edge. "waits" counts the
    // cycles spent with in_ready low.
    task automatic applyStimulus(input logic mode, input logic [M-1:0] f,
                                 input logic [N-1:0] a0, input logic [N-1:0] a1,
                                 input logic [N-1:0] e0, input logic [N-1:0] e1,
                                 input logic [N-1:0] erest, input logic [M-1:0] ef,
                                 output int waits);
        exp_t x;
        logic hs;
        for (int ch = 0; ch < M; ch++) begin
            x.data[ch] = (ch == 0) ? e0 : (ch == 1) ? e1 : erest;
        end
        x.f = ef;
        sb.push_back(x);
        in_mode               = mode;
        input_f_bits          = f;
        input_activaciones    = '0;
        input_activaciones[0] = a0;
        input_activaciones[1] = a1;
        in_valid              = 1'b1;
        waits = 0;
        hs    = 1'b0;
        while (!hs && waits < 50) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
            if (!hs) waits++;
        end
        if (!hs) begin
            checks++;
            errors++;
            $display("[TB] FAIL handshake_timeout actual=no_accept required=accept");
        end
        in_valid = 1'b0;
    endtask

    // Waits, with a bound, until every queued word has been delivered.
    // It then steps past the next rising edge so that the counter has
    // absorbed the last handshake.
    task automatic waitDrain();
        for (int t = 0; t < 100 && sb.size() != 0; t++) @(negedge clk);
        checkOutput("drain_empty", 256'(sb.size()), 256'(0));
        @(posedge clk);
        #1;
    endtask

    // Asserts reset for two cycles, discards anything still expected and
    // releases just after a rising edge.
    task automatic doReset();
        rst         = 1'b0;
        in_valid    = 1'b0;
        clear_count = 1'b0;
        out_ready   = 1'b1;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Monitor: on each output handshake, pop the oldest expected word-set
    // and compare it. Also keep a saturating flip-count model built from
    // the expected flags, and compare it every cycle.
    initial begin
        cnt_model = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                cnt_model = '0;
            end else begin
                checkOutput("flip_count", 256'(flip_count), 256'(cnt_model));
                mon_sum = 0;
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_output actual=%0h required=none",
                                 salida_activaciones[0]);
                    end else begin
                        mon_e = sb.pop_front();
                        checkOutput("out_data", 256'(salida_activaciones), 256'(mon_e.data));
                        checkOutput("out_f", 256'(salida_f_bits), 256'(mon_e.f));
                        mon_sum = $countones(mon_e.f);
                    end
                end
                if (clear_count) begin
                    cnt_model = '0;
                end else if (out_valid && out_ready) begin
                    mon_sum   = mon_sum + int'(cnt_model);
                    cnt_model = (mon_sum > 15) ? 4'd15 : CNT_W'(mon_sum);
                end
            end
        end
    end

    logic [N-1:0] tp_a[8] = '{16'h0000, 16'h1111, 16'h2222, 16'h3333,
                              16'h4444, 16'h5555, 16'h6666, 16'h7777};
    logic [N-1:0] tp_e[8] = '{16'h0000, 16'hEEEE, 16'h2222, 16'hCCCC,
                              16'h4444, 16'hAAAA, 16'h6666, 16'h8888};

    initial begin
        rst                = 1'b0;
        in_valid           = 1'b0;
        in_mode            = 1'b0;
        input_f_bits       = '0;
        input_activaciones = '0;
        out_ready          = 1'b1;
        clear_count        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Reset state.
        checkOutput("rst_out_valid", 256'(out_valid), 256'(0));
        checkOutput("rst_in_ready", 256'(in_ready), 256'(1));
        checkOutput("rst_data", 256'(salida_activaciones), 256'(0));
        checkOutput("rst_f", 256'(salida_f_bits), 256'(0));
        checkOutput("rst_count", 256'(flip_count), 256'(0));

        // External mode: channel 0 F0F0 flipped, channel 1 1234 passed.
        $display("[TB] external mode");
        applyStimulus(1'b0, 16'h0001, 16'hF0F0, 16'h1234,
                      16'h0F0F, 16'h1234, 16'h0000, 16'h0001, w);
        checkOutput("ext_latency_s1", 256'(out_valid), 256'(0));
        @(posedge clk);
        #1;
        checkOutput("ext_latency_s2", 256'(out_valid), 256'(1));
        checkOutput("ext_ch0", 256'(salida_activaciones[0]), 256'(16'h0F0F));
        waitDrain();
        checkOutput("ext_count", 256'(flip_count), 256'(1));

        // Auto mode on channel 0: FFFF flips, 00FF ties, FF00 flips.
        $display("[TB] auto mode");
        doReset();
        applyStimulus(1'b1, '0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0001, w);
        applyStimulus(1'b1, '0, 16'h00FF, 16'h0000, 16'h00FF, 16'h0000, 16'h0000, 16'h0000, w);
        applyStimulus(1'b1, '0, 16'hFF00, 16'h0000, 16'h00FF, 16'h0000, 16'h0000, 16'h0001, w);
        waitDrain();

        // Backpressure: the first output is held for 3 cycles.
        $display("[TB] backpressure");
        doReset();
        out_ready = 1'b0;
        fork
            begin
                applyStimulus(1'b1, '0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0001, w);
                applyStimulus(1'b1, '0, 16'h00FF, 16'h0000, 16'h00FF, 16'h0000, 16'h0000, 16'h0000, w);
                applyStimulus(1'b1, '0, 16'hFF00, 16'h0000, 16'h00FF, 16'h0000, 16'h0000, 16'h0001, w);
                applyStimulus(1'b1, '0, 16'h0F0F, 16'h0000, 16'h0F0F, 16'h0000, 16'h0000, 16'h0000, w);
            end
            begin
                for (int t = 0; t < 20 && !out_valid; t++) @(negedge clk);
                checkOutput("bp_first_valid", 256'(out_valid), 256'(1));
                for (int c = 0; c < 3; c++) begin
                    checkOutput("bp_hold_valid", 256'(out_valid), 256'(1));
                    checkOutput("bp_hold_data", 256'(salida_activaciones[0]), 256'(16'h0000));
                    checkOutput("bp_hold_f", 256'(salida_f_bits), 256'(16'h0001));
                    checkOutput("bp_in_ready_low", 256'(in_ready), 256'(0));
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        waitDrain();

        // Throughput: 8 back-to-back external words, alternating flips.
        $display("[TB] throughput");
        doReset();
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    applyStimulus(1'b0, M'(i % 2), tp_a[i], 16'h0000,
                                  tp_e[i], 16'h0000, 16'h0000, M'(i % 2), w);
                    checkOutput("tp_no_wait", 256'(w), 256'(0));
                end
            end
            begin
                int run;
                run = 0;
                for (int t = 0; t < 20 && !out_valid; t++) @(negedge clk);
                while (out_valid && run < 20) begin
                    run++;
                    @(negedge clk);
                end
                checkOutput("tp_run_length", 256'(run), 256'(8));
            end
        join
        waitDrain();

        // Counter saturation with all 16 channels flipping, then clear
        // in the same cycle as an output handshake.
        $display("[TB] counter");
        doReset();
        applyStimulus(1'b0, 16'hFFFF, 16'h0000, 16'h0000,
                      16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, w);
        waitDrain();
        checkOutput("cnt_saturated", 256'(flip_count), 256'(15));
        applyStimulus(1'b0, 16'hFFFF, 16'h0000, 16'h0000,
                      16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, w);
        @(posedge clk);
        #1;
        checkOutput("cnt_clear_handshake", 256'(out_valid && out_ready), 256'(1));
        clear_count = 1'b1;
        @(posedge clk);
        #1;
        clear_count = 1'b0;
        checkOutput("cnt_cleared", 256'(flip_count), 256'(0));
        applyStimulus(1'b0, 16'h0003, 16'h0000, 16'h0000,
                      16'hFFFF, 16'hFFFF, 16'h0000, 16'h0003, w);
        waitDrain();
        checkOutput("cnt_after_clear", 256'(flip_count), 256'(2));

        // Reset while both stages are full.
        $display("[TB] reset mid-stream");
        out_ready = 1'b0;
        applyStimulus(1'b1, '0, 16'h1234, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 16'h0000, w);
        applyStimulus(1'b1, '0, 16'h5678, 16'h0000, 16'h5678, 16'h0000, 16'h0000, 16'h0000, w);
        checkOutput("mid_full_valid", 256'(out_valid), 256'(1));
        checkOutput("mid_full_in_ready", 256'(in_ready), 256'(0));
        rst = 1'b0;
        sb.delete();
        #1;
        checkOutput("mid_rst_valid", 256'(out_valid), 256'(0));
        checkOutput("mid_rst_data", 256'(salida_activaciones), 256'(0));
        checkOutput("mid_rst_f", 256'(salida_f_bits), 256'(0));
        checkOutput("mid_rst_count", 256'(flip_count), 256'(0));
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b1;
        out_ready = 1'b1;
        checkOutput("mid_in_ready", 256'(in_ready), 256'(1));
        applyStimulus(1'b1, '0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0001, w);
        waitDrain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
